// File: rtl/dense_seq_pkg.sv
// Shared types, constants and helpers for the dense layer sequencer.
package dense_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFeed,
    StDrain,
    StDump,
    StDone
  } state_e;

  // Buffer select codes: ping reads buf1 / writes buf2, pong is the reverse.
  localparam logic [1:0] BUF_SEL_PING = 2'b11;
  localparam logic [1:0] BUF_SEL_PONG = 2'b10;

  // Widest lane count the mask helper supports; callers slice the low lanes.
  localparam int unsigned MaxLanes = 64;

  // Thermometer mask with the low `cnt` lanes set.
  function automatic logic [MaxLanes-1:0] lane_mask(input int unsigned cnt);
    if (cnt >= MaxLanes) begin
      return '1;
    end
    return (MaxLanes'(1) << cnt) - MaxLanes'(1);
  endfunction

endpackage

// File: rtl/dense_seq_wr.sv
// Result write-back stage: walks the active lanes of one block through a
// ready/valid output port, holding address and select while stalled.
module dense_seq_wr #(
  parameter int unsigned N_PE   = 8,
  parameter int unsigned ADDR_W = 16,
  localparam int unsigned CW    = $clog2(N_PE + 1),
  localparam int unsigned SW    = $clog2(N_PE)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CW-1:0]     active_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              ready_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [SW-1:0]     sel_o,
  output logic              last_o
);

  logic              en_q;
  logic [SW-1:0]     j_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic              accept;

  assign accept    = en_q && ready_i;
  assign last_o    = accept && (CW'(j_q) == cnt_q - CW'(1));
  assign wr_en_o   = en_q;
  assign wr_addr_o = en_q ? base_q + ADDR_W'(j_q) : '0;
  assign sel_o     = en_q ? j_q : '0;

  // Lane counter: load on start, advance only on an accepted write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q   <= 1'b0;
      j_q    <= '0;
      cnt_q  <= '0;
      base_q <= '0;
    end else if (start_i) begin
      en_q   <= 1'b1;
      j_q    <= '0;
      cnt_q  <= active_i;
      base_q <= base_i;
    end else if (accept) begin
      if (last_o) begin
        en_q <= 1'b0;
      end else begin
        j_q <= j_q + SW'(1);
      end
    end
  end

endmodule

// File: rtl/dense_seq.sv
// Dense layer sequencer: tiles output neurons into N_PE-lane blocks, streams
// weights/inputs, paces MAC controls and writes each block's results back.
module dense_seq
  import dense_seq_pkg::*;
#(
  parameter int unsigned N_PE     = 8,
  parameter int unsigned DPG      = 4,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LAT_RD   = 1,
  parameter int unsigned LAT_PIPE = 4,
  localparam int unsigned SW      = $clog2(N_PE),
  localparam int unsigned MW      = $clog2(DPG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_in_len,
  input  logic [LEN_W-1:0]  cfg_out_len,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic              cfg_pingpong,
  output logic [1:0]        buf_sel,
  output logic [N_PE-1:0]   w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              x_rd_en,
  output logic [ADDR_W-1:0] x_rd_addr,
  output logic [N_PE-1:0]   shift_en,
  output logic              acc_clr,
  output logic [MW-1:0]     mac_valid,
  output logic              res_latch,
  output logic [SW-1:0]     res_sel,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  input  logic              out_wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CW = $clog2(N_PE + 1);
  localparam int unsigned GW = (DPG > 1) ? $clog2(DPG) : 1;
  localparam int unsigned DW = $clog2(LAT_RD + LAT_PIPE + 1);

  state_e            state_q;
  logic [LEN_W-1:0]  in_len_q, rem_q, k_q;
  logic [ADDR_W-1:0] in_base_q, w_blk_q, out_blk_q;
  logic              pp_q, err_q;
  logic [GW-1:0]     g_q;
  logic [DW-1:0]     drain_q;

  logic                issue, k_last, grp_full, wr_last;
  logic [CW-1:0]       act;
  logic [MaxLanes-1:0] mask_full;
  logic [N_PE-1:0]     mask;
  logic [MW-1:0]       mac_issue;
  logic                unused_mask;

  // rem_q counts outputs still to produce, so the active lane count needs no divide.
  assign issue       = (state_q == StFeed);
  assign k_last      = (k_q == in_len_q - LEN_W'(1));
  assign grp_full    = (g_q == GW'(DPG - 1));
  assign act         = (rem_q >= LEN_W'(N_PE)) ? CW'(N_PE) : CW'(rem_q);
  assign mask_full   = lane_mask(32'(act));
  assign mask        = mask_full[N_PE-1:0];
  assign unused_mask = ^mask_full;

  assign x_rd_en   = issue;
  assign x_rd_addr = issue ? in_base_q + ADDR_W'(k_q) : '0;
  assign w_rd_en   = issue ? mask : '0;
  assign w_rd_addr = issue ? w_blk_q + ADDR_W'(k_q) : '0;
  assign acc_clr   = issue && (k_q == '0);
  assign res_latch = (state_q == StDrain) && (drain_q == DW'(LAT_RD + LAT_PIPE - 1));
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = done && err_q;
  assign buf_sel   = busy ? (pp_q ? BUF_SEL_PING : BUF_SEL_PONG) : 2'b00;

  // Group size attached to each read: full groups, or the partial tail on the last read.
  always_comb begin
    mac_issue = '0;
    if (issue) begin
      if (grp_full) begin
        mac_issue = MW'(DPG);
      end else if (k_last) begin
        mac_issue = MW'(g_q) + MW'(1);
      end
    end
  end

  // Read-latency delay line so shift_en/mac_valid line up with returned data.
  logic [N_PE-1:0] pipe_mask_q [LAT_RD];
  logic [MW-1:0]   pipe_mac_q  [LAT_RD];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT_RD); i++) begin
        pipe_mask_q[i] <= '0;
        pipe_mac_q[i]  <= '0;
      end
    end else begin
      pipe_mask_q[0] <= issue ? mask : '0;
      pipe_mac_q[0]  <= mac_issue;
      for (int i = 1; i < int'(LAT_RD); i++) begin
        pipe_mask_q[i] <= pipe_mask_q[i-1];
        pipe_mac_q[i]  <= pipe_mac_q[i-1];
      end
    end
  end

  assign shift_en  = pipe_mask_q[LAT_RD-1];
  assign mac_valid = pipe_mac_q[LAT_RD-1];

  // Main sequencer: config latch, block walk, drain timing and completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      in_len_q  <= '0;
      rem_q     <= '0;
      k_q       <= '0;
      g_q       <= '0;
      drain_q   <= '0;
      in_base_q <= '0;
      w_blk_q   <= '0;
      out_blk_q <= '0;
      pp_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            in_len_q  <= cfg_in_len;
            rem_q     <= cfg_out_len;
            in_base_q <= cfg_in_base;
            w_blk_q   <= cfg_w_base;
            out_blk_q <= cfg_out_base;
            pp_q      <= cfg_pingpong;
            k_q       <= '0;
            g_q       <= '0;
            drain_q   <= '0;
            if (cfg_in_len == '0 || cfg_out_len == '0) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              err_q   <= 1'b0;
              state_q <= StFeed;
            end
          end
        end
        StFeed: begin
          k_q <= k_q + LEN_W'(1);
          g_q <= grp_full ? '0 : g_q + GW'(1);
          if (k_last) begin
            drain_q <= '0;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          drain_q <= drain_q + DW'(1);
          if (res_latch) begin
            state_q <= StDump;
          end
        end
        StDump: begin
          if (wr_last) begin
            if (rem_q > LEN_W'(N_PE)) begin
              rem_q     <= rem_q - LEN_W'(N_PE);
              w_blk_q   <= w_blk_q + ADDR_W'(in_len_q);
              out_blk_q <= out_blk_q + ADDR_W'(N_PE);
              k_q       <= '0;
              g_q       <= '0;
              state_q   <= StFeed;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  dense_seq_wr #(
    .N_PE  (N_PE),
    .ADDR_W(ADDR_W)
  ) u_wr (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (res_latch),
    .active_i (act),
    .base_i   (out_blk_q),
    .ready_i  (out_wr_ready),
    .wr_en_o  (out_wr_en),
    .wr_addr_o(out_wr_addr),
    .sel_o    (res_sel),
    .last_o   (wr_last)
  );

endmodule

// File: tb/tb_dense_seq.sv
// Directed bench for dense_seq: event log at negedge, per-scenario tasks check it.
module tb_dense_seq;
  localparam int unsigned N_PE = 8, DPG = 4, LEN_W = 16, ADDR_W = 16;
  localparam int unsigned LAT_RD = 1, LAT_PIPE = 4;

  logic clk = 1'b0;
  logic rst, start, cfg_pingpong, out_wr_ready;
  logic [15:0] cfg_in_len, cfg_out_len, cfg_w_base, cfg_in_base, cfg_out_base;
  logic [1:0]  buf_sel;
  logic [7:0]  w_rd_en, shift_en;
  logic [15:0] w_rd_addr, x_rd_addr, out_wr_addr;
  logic        x_rd_en, acc_clr, res_latch, out_wr_en, busy, done, err;
  logic [2:0]  mac_valid, res_sel;

  always #5 clk = ~clk;

  dense_seq #(.N_PE(N_PE), .DPG(DPG), .LEN_W(LEN_W), .ADDR_W(ADDR_W),
              .LAT_RD(LAT_RD), .LAT_PIPE(LAT_PIPE)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_in_len(cfg_in_len),
    .cfg_out_len(cfg_out_len), .cfg_w_base(cfg_w_base), .cfg_in_base(cfg_in_base),
    .cfg_out_base(cfg_out_base), .cfg_pingpong(cfg_pingpong), .buf_sel(buf_sel),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
    .shift_en(shift_en), .acc_clr(acc_clr), .mac_valid(mac_valid), .res_latch(res_latch),
    .res_sel(res_sel), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .out_wr_ready(out_wr_ready), .busy(busy), .done(done), .err(err)
  );

  int checks = 0, errors = 0;

  // Event log, cleared whenever an accepted start is seen; times are cycles after start.
  int ncyc = 0, t0 = 0, rel = 0;
  int nx = 0, nmac = 0, nacc = 0, nlatch = 0, nwr = 0, ndone = 0, nhold = 0, w_orphan = 0;
  logic [15:0] x_addr [64], w_addr [64], wr_addr [64], hold_addr [64];
  logic [7:0]  w_en [64];
  int x_cyc [64], wr_sel [64], mac_cyc [8], mac_val [8], acc_cyc [8], latch_cyc [8];
  int done_cyc = -1;
  logic done_err = 1'b0, busy_at2 = 1'b0;
  logic [1:0] bs_at2 = 2'b00;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (start && !busy && !rst) begin
      t0 = ncyc; nx = 0; nmac = 0; nacc = 0; nlatch = 0; nwr = 0; ndone = 0;
      nhold = 0; w_orphan = 0; done_cyc = -1;
    end
    rel = ncyc - t0;
    if (rel == 2) begin bs_at2 = buf_sel; busy_at2 = busy; end
    if (x_rd_en) begin
      if (nx < 64) begin
        x_addr[nx] = x_rd_addr; w_addr[nx] = w_rd_addr; w_en[nx] = w_rd_en; x_cyc[nx] = rel;
      end
      nx = nx + 1;
    end
    if (w_rd_en != 8'h00 && !x_rd_en) w_orphan = w_orphan + 1;
    if (mac_valid != 3'd0) begin
      if (nmac < 8) begin mac_val[nmac] = int'(mac_valid); mac_cyc[nmac] = rel; end
      nmac = nmac + 1;
    end
    if (acc_clr) begin if (nacc < 8) acc_cyc[nacc] = rel; nacc = nacc + 1; end
    if (res_latch) begin if (nlatch < 8) latch_cyc[nlatch] = rel; nlatch = nlatch + 1; end
    if (out_wr_en && out_wr_ready) begin
      if (nwr < 64) begin wr_addr[nwr] = out_wr_addr; wr_sel[nwr] = int'(res_sel); end
      nwr = nwr + 1;
    end
    if (out_wr_en && !out_wr_ready) begin
      if (nhold < 64) hold_addr[nhold] = out_wr_addr;
      nhold = nhold + 1;
    end
    if (done) begin done_cyc = rel; done_err = err; ndone = ndone + 1; end
  end

  task automatic run_op(input int in_len, input int out_len, input logic [15:0] wb,
                        input logic pp, input bit stall, input bit restart,
                        output bit timed_out);
    cfg_in_len = 16'(in_len); cfg_out_len = 16'(out_len); cfg_w_base = wb;
    cfg_in_base = 16'h0100; cfg_out_base = 16'h2000; cfg_pingpong = pp;
    @(posedge clk); #2; start = 1'b1;
    timed_out = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #2;
      if (c == 1) begin
        start = 1'b0;
        cfg_in_len = 16'd3; cfg_out_len = 16'd5; cfg_w_base = 16'h5555;
        cfg_in_base = 16'h7777; cfg_out_base = 16'h9999; cfg_pingpong = ~pp;
      end
      if (restart && c == 5) begin start = 1'b1; cfg_in_len = 16'd2; end
      if (restart && c == 6) start = 1'b0;
      out_wr_ready = !(stall && c >= 16 && c <= 18);
      if (ndone > 0) begin timed_out = 1'b0; break; end
    end
    out_wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_wr_ready = 1'b1;
    cfg_in_len = '0; cfg_out_len = '0; cfg_w_base = '0; cfg_in_base = '0;
    cfg_out_base = '0; cfg_pingpong = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({buf_sel, w_rd_en, w_rd_addr, x_rd_en, x_rd_addr, shift_en, acc_clr, mac_valid,
         res_latch, res_sel, out_wr_en, out_wr_addr, busy, done, err} !== '0) begin
      errors++; $display("FAIL reset_outputs got busy=%b x_rd_en=%b buf_sel=%b want all 0",
                         busy, x_rd_en, buf_sel);
    end
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    bit to;
    run_op(8, 8, 16'h1000, 1'b1, 1'b0, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL s1_timeout got no done want done"); end
    checks++; if (nx != 8) begin errors++; $display("FAIL s1_nreads got %0d want 8", nx); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (x_addr[i] !== 16'h0100 + 16'(i) || x_cyc[i] != i + 1) begin
        errors++; $display("FAIL s1_x[%0d] got %h@%0d want %h@%0d", i, x_addr[i], x_cyc[i],
                           16'h0100 + 16'(i), i + 1); end
      checks++; if (w_addr[i] !== 16'h1000 + 16'(i) || w_en[i] !== 8'hFF) begin
        errors++; $display("FAIL s1_w[%0d] got %h/%h want %h/ff", i, w_addr[i], w_en[i],
                           16'h1000 + 16'(i)); end
    end
    checks++; if (nmac != 2 || mac_val[0] != 4 || mac_cyc[0] != 5 || mac_val[1] != 4 || mac_cyc[1] != 9) begin
      errors++; $display("FAIL s1_mac got n=%0d %0d@%0d %0d@%0d want 4@5 4@9", nmac,
                         mac_val[0], mac_cyc[0], mac_val[1], mac_cyc[1]); end
    checks++; if (nacc != 1 || acc_cyc[0] != 1) begin
      errors++; $display("FAIL s1_acc got n=%0d @%0d want 1@1", nacc, acc_cyc[0]); end
    checks++; if (nlatch != 1 || latch_cyc[0] != 13) begin
      errors++; $display("FAIL s1_latch got n=%0d @%0d want 1@13", nlatch, latch_cyc[0]); end
    checks++; if (nwr != 8) begin errors++; $display("FAIL s1_nwr got %0d want 8", nwr); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (wr_addr[i] !== 16'h2000 + 16'(i) || wr_sel[i] != i) begin
        errors++; $display("FAIL s1_wr[%0d] got %h sel %0d want %h sel %0d", i, wr_addr[i],
                           wr_sel[i], 16'h2000 + 16'(i), i); end
    end
    checks++; if (ndone != 1 || done_cyc != 22 || done_err !== 1'b0) begin
      errors++; $display("FAIL s1_done got n=%0d @%0d err=%b want 1@22 err=0", ndone,
                         done_cyc, done_err); end
    checks++; if (bs_at2 !== 2'b11 || busy_at2 !== 1'b1) begin
      errors++; $display("FAIL s1_bufsel got %b busy %b want 11 busy 1", bs_at2, busy_at2); end
  endtask

  task automatic test_remainder();
    bit to;
    run_op(4, 11, 16'h1000, 1'b0, 1'b0, 1'b0, to);
    checks++; if (to || nx != 8) begin errors++; $display("FAIL s2_nreads got %0d to=%b want 8", nx, to); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (w_addr[i] !== 16'h1000 + 16'(i) || w_en[i] !== ((i < 4) ? 8'hFF : 8'h07)
                    || x_addr[i] !== 16'h0100 + 16'(i % 4)) begin
        errors++; $display("FAIL s2_rd[%0d] got w %h/%h x %h", i, w_addr[i], w_en[i], x_addr[i]); end
    end
    checks++; if (x_cyc[0] != 1 || x_cyc[4] != 18) begin
      errors++; $display("FAIL s2_blk_start got %0d,%0d want 1,18", x_cyc[0], x_cyc[4]); end
    checks++; if (nlatch != 2 || latch_cyc[0] != 9 || latch_cyc[1] != 26 || nacc != 2 || acc_cyc[1] != 18) begin
      errors++; $display("FAIL s2_latch_acc got latch %0d@%0d,%0d acc %0d@%0d", nlatch,
                         latch_cyc[0], latch_cyc[1], nacc, acc_cyc[1]); end
    checks++; if (nwr != 11) begin errors++; $display("FAIL s2_nwr got %0d want 11", nwr); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (wr_addr[i] !== 16'h2000 + 16'(i) || wr_sel[i] != i % 8) begin
        errors++; $display("FAIL s2_wr[%0d] got %h sel %0d", i, wr_addr[i], wr_sel[i]); end
    end
    checks++; if (done_cyc != 30 || done_err !== 1'b0 || bs_at2 !== 2'b10) begin
      errors++; $display("FAIL s2_done got @%0d err=%b bs=%b want @30 err=0 bs=10", done_cyc,
                         done_err, bs_at2); end
  endtask

  task automatic test_partial_group();
    bit to;
    run_op(6, 8, 16'hFFFE, 1'b1, 1'b0, 1'b0, to);
    checks++; if (to || nmac != 2 || mac_val[0] != 4 || mac_cyc[0] != 5 || mac_val[1] != 2 || mac_cyc[1] != 7) begin
      errors++; $display("FAIL s3_mac got n=%0d %0d@%0d %0d@%0d want 4@5 2@7", nmac,
                         mac_val[0], mac_cyc[0], mac_val[1], mac_cyc[1]); end
    checks++; if (nacc != 1) begin errors++; $display("FAIL s3_acc got %0d want 1", nacc); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (w_addr[i] !== 16'hFFFE + 16'(i)) begin
        errors++; $display("FAIL s3_wrap[%0d] got %h want %h", i, w_addr[i], 16'hFFFE + 16'(i)); end
    end
    checks++; if (nlatch != 1 || latch_cyc[0] != 11 || done_cyc != 20) begin
      errors++; $display("FAIL s3_timing got latch@%0d done@%0d want 11,20", latch_cyc[0], done_cyc); end
  endtask

  task automatic test_stall();
    bit to;
    run_op(8, 8, 16'h1000, 1'b1, 1'b1, 1'b0, to);
    checks++; if (to || nhold != 3) begin errors++; $display("FAIL s4_nhold got %0d want 3", nhold); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (hold_addr[i] !== 16'h2002) begin
        errors++; $display("FAIL s4_hold[%0d] got %h want 2002", i, hold_addr[i]); end
    end
    checks++; if (nwr != 8 || wr_addr[2] !== 16'h2002 || wr_addr[7] !== 16'h2007) begin
      errors++; $display("FAIL s4_wr got n=%0d %h %h", nwr, wr_addr[2], wr_addr[7]); end
    checks++; if (done_cyc != 25) begin errors++; $display("FAIL s4_done got @%0d want 25", done_cyc); end
  endtask

  task automatic test_zero_len();
    bit to;
    run_op(0, 8, 16'h1000, 1'b1, 1'b0, 1'b0, to);
    checks++; if (to || done_cyc != 1 || done_err !== 1'b1 || ndone != 1) begin
      errors++; $display("FAIL s5_in0 got done@%0d err=%b n=%0d want @1 err=1", done_cyc, done_err, ndone); end
    checks++; if (nx != 0 || w_orphan != 0 || nmac != 0) begin
      errors++; $display("FAIL s5_in0_reads got x=%0d w=%0d mac=%0d want 0", nx, w_orphan, nmac); end
    run_op(4, 0, 16'h1000, 1'b1, 1'b0, 1'b0, to);
    checks++; if (to || done_cyc != 1 || done_err !== 1'b1 || nx != 0 || w_orphan != 0) begin
      errors++; $display("FAIL s5_out0 got done@%0d err=%b x=%0d", done_cyc, done_err, nx); end
    run_op(8, 8, 16'h1000, 1'b1, 1'b0, 1'b1, to);
    checks++; if (to || done_cyc != 22 || ndone != 1 || nx != 8 || nwr != 8 || x_addr[7] !== 16'h0107) begin
      errors++; $display("FAIL s5_restart got done@%0d n=%0d x=%0d wr=%0d", done_cyc, ndone, nx, nwr); end
  endtask

  task automatic test_abort();
    bit to;
    cfg_in_len = 16'd8; cfg_out_len = 16'd8; cfg_w_base = 16'h1000;
    cfg_in_base = 16'h0100; cfg_out_base = 16'h2000; cfg_pingpong = 1'b1;
    @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #2; rst = 1'b1;
    #1;
    checks++;
    if ({buf_sel, w_rd_en, w_rd_addr, x_rd_en, x_rd_addr, shift_en, acc_clr, mac_valid,
         res_latch, res_sel, out_wr_en, out_wr_addr, busy, done, err} !== '0) begin
      errors++; $display("FAIL s6_abort_outputs got busy=%b x_rd_en=%b shift=%h want all 0",
                         busy, x_rd_en, shift_en);
    end
    @(posedge clk); #2; rst = 1'b0;
    repeat (25) @(posedge clk);
    #2;
    checks++; if (ndone != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL s6_no_done got n=%0d busy=%b want 0", ndone, busy); end
    run_op(8, 8, 16'h1000, 1'b1, 1'b0, 1'b0, to);
    checks++; if (to || done_cyc != 22 || nx != 8 || nwr != 8 || nlatch != 1 || latch_cyc[0] != 13) begin
      errors++; $display("FAIL s6_rerun got done@%0d x=%0d wr=%0d latch@%0d", done_cyc, nx, nwr, latch_cyc[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_remainder();
    test_partial_group();
    test_stall();
    test_zero_len();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dense_seq.md
Name: dense_seq

Overview:
Parametrised dense (fully-connected) layer sequencer for the PE array, the next generation of the existing dense controller. Tiles output neurons into blocks of N_PE lanes, streams weights and inputs from the buffers, and pulses MAC/accumulate/latch controls at DENSE_PER_GO granularity. Writes each block's results back with a ready/valid stall. Remainder output and input blocks, configurable base addresses and ping-pong buffer selection are handled in hardware.

Parameters:
N_PE, 8, PE lanes (output neurons per block); must be ≥2.
DPG, 4, inputs accumulated per MAC valid pulse (dense per go).
LEN_W, 16, width of the length config fields.
ADDR_W, 16, buffer address width.
LAT_RD, 1, buffer read latency in cycles.
LAT_PIPE, 4, cycles from the last shift_en to result-ready (MAC + adder tree + NL).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle launch pulse
cfg_in_len  in  LEN_W  number of input neurons
cfg_out_len  in  LEN_W  number of output neurons
cfg_w_base  in  ADDR_W  weight bank base address
cfg_in_base  in  ADDR_W  input vector base address
cfg_out_base  in  ADDR_W  output vector base address
cfg_pingpong  in  1  1: read buf1 / write buf2; 0: the reverse
buf_sel  out  2  2'b11 when the latched pingpong = 1, else 2'b10
w_rd_en  out  N_PE  per-lane weight bank read enable
w_rd_addr  out  ADDR_W  shared weight bank address
x_rd_en  out  1  input read enable
x_rd_addr  out  ADDR_W  input address
shift_en  out  N_PE  per-lane operand load into the PE
acc_clr  out  1  accumulator clear
mac_valid  out  $clog2(DPG+1)  element count of the group being accumulated; 0 = idle
res_latch  out  1  latch PE results
res_sel  out  $clog2(N_PE)  result lane mux select
out_wr_en  out  1  output write valid
out_wr_addr  out  ADDR_W  output address
out_wr_ready  in  1  output write accept
busy  out  1  high whenever the FSM is not in IDLE
done  out  1  one-cycle completion pulse
err  out  1  qualifies done; high for a zero-length config

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, all counters clear. Reset asserted mid-operation aborts immediately; no done pulse is generated.
- In IDLE, start latches all cfg_* fields; cfg changes after that are ignored. start is ignored while busy.
- Block math: OB = out_len/N_PE; extra = out_len%N_PE; OBe = OB + (extra≠0).
- Active lanes: N_PE for block ob < OB; the low `extra` lanes for the last remainder block.
- FSM states: IDLE → FEED → DRAIN → DUMP → (FEED for the next ob | DONE) → IDLE.
- Zero-length config: if in_len == 0 or out_len == 0, go IDLE → DONE. done=1 and err=1 one cycle after start; no reads are issued.
- FEED:
  - acc_clr=1 in the first FEED cycle of each block.
  - For k = 0..in_len-1, one read per cycle: x_rd_en=1, x_rd_addr = in_base+k.
  - w_rd_en = active-lane mask; w_rd_addr = w_base + ob*in_len + k.
  - Address arithmetic is modulo 2^ADDR_W.
- Issue-to-load timing:
  - shift_en = active mask at cycle k+LAT_RD.
  - In that same cycle, mac_valid = DPG when (k+1)%DPG == 0; mac_valid = in_len%DPG when k = in_len-1 and the group is partial; otherwise 0.
- DRAIN: starts after the last read. res_latch pulses exactly LAT_PIPE cycles after the last shift_en, then the FSM enters DUMP.
- DUMP:
  - Lane counter j starts at 0: res_sel=j, out_wr_en=1, out_wr_addr = out_base + ob*N_PE + j.
  - j advances only on out_wr_en && out_wr_ready; address and select are held stable while stalled.
  - When the write for j = active-1 is accepted: go to FEED with ob+1 if ob+1 < OBe, otherwise go to DONE.
- DONE: done=1, err=0 for one cycle, then IDLE.
- busy=1 in every state except IDLE. buf_sel is driven from the latched pingpong for the whole operation.

Decomposition:
- Shared package dense_seq_pkg: state enum (IDLE, FEED, DRAIN, DUMP, DONE), the BUF_SEL_PING / BUF_SEL_PONG constants, and the lane-mask function (count → N_PE-bit mask).
- One sub-module, dense_seq_wr: the DUMP lane counter plus the ready/valid write stage. Inputs: start pulse, active count, base address. Outputs: last-accept pulse.

Test Plan:
1. N_PE=8, DPG=4, in_len=8, out_len=8, ready=1 → x_rd_addr in_base..+7; mac_valid = 4 at load cycles 3 and 7; one res_latch; 8 writes to out_base+0..7; one done, err=0.
2. out_len=11, in_len=4 → two blocks. Block 1 w_rd_en=8'hFF, w_rd_addr = w_base+0..3. Block 2 w_rd_en=8'h07, w_rd_addr = w_base+4..7. Writes go to out_base+0..10.
3. in_len=6, out_len=8 → mac_valid pulses 4 then 2, at load cycles 3 and 5; acc_clr once per block.
4. out_len=8, out_wr_ready held low for 3 cycles while j=2 → out_wr_addr held at out_base+2 with out_wr_en high; done arrives exactly 3 cycles later than in scenario 1.
5. in_len=0 → done=1, err=1 one cycle after start; x_rd_en and w_rd_en never assert. A second start while busy (scenario 1 running) is ignored.
6. Assert rst during FEED of block 1 → all outputs 0 and busy=0; a fresh start then completes scenario 1 exactly.
